fetch_unit_8085: RTL and testbench
==================================

# fetch_unit_8085

Instruction prefetch stage directly upstream of the multi-cycle 8085 datapath's decode/execute logic. It reads 16-bit instruction words from the synchronous instruction memory at a self-incrementing fetch address. It buffers them in a small FIFO and hands them to decode over a valid/ready handshake. Taken branches, jumps and calls flush the queue through a redirect input.

## Interface
- `ADDR_W`, default 8: word-address width; fetch address wraps modulo 2^ADDR_W.
- `DATA_W`, default 16: instruction word width.
- `DEPTH`, default 4: prefetch queue entries; must be a power of 2, ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `halt` in 1: 1 = issue no new memory reads; queue and in-flight read unaffected.
- `redirect` in 1: 1 = flush and restart fetch at `redirect_pc`.
- `redirect_pc` in ADDR_W: new fetch address, sampled when `redirect`=1.
- `mem_rd` out 1: read request to instruction memory.
- `mem_addr` out ADDR_W: read address; equals `fetch_pc`.
- `mem_rdata` in DATA_W: read data, valid exactly one cycle after a cycle with `mem_rd`=1.
- `instr_valid` out 1: queue head valid.
- `instr` out DATA_W: queue head instruction word.
- `instr_pc` out ADDR_W: address the head word was fetched from.
- `instr_ready` in 1: decode accepts head this cycle.
- `fetch_pc` out ADDR_W: next address to be requested.
- `q_count` out $clog2(DEPTH)+1: current queue occupancy.

## Operation
- Reset values: `fetch_pc`=0, `mem_addr`=0, `mem_rd`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `q_count`=0, in-flight flag=0.
- Issue rule: `mem_rd` = !halt && !redirect && (q_count + inflight < DEPTH). The rule is conservative: a same-cycle pop does not create a credit. This guarantees a response is never dropped for lack of space.
- On issue: `fetch_pc` <= `fetch_pc`+1 (wraps 2^ADDR_W−1 → 0); in-flight flag <= 1 and in-flight address <= `fetch_pc`. With no issue, the in-flight flag <= 0.
- Response: in the cycle after an issue, the word is pushed with its address unless that cycle has `redirect`=1, in which case it is discarded.
- Pop: occurs when `instr_valid` && `instr_ready`. A push and a pop in the same cycle leave `q_count` unchanged. A word pushed into an empty queue is not visible until the next cycle (no bypass).
- Redirect has priority over issue, push and pop. In the redirect cycle:
  - the queue is emptied and `q_count` <= 0;
  - any response arriving that cycle is dropped;
  - the in-flight flag is cleared;
  - `fetch_pc` <= `redirect_pc`;
  - no pop is counted, even if `instr_ready`=1.
- Issue resumes the following cycle if `halt`=0.
- `halt` asserted mid-stream: an in-flight read still completes and is queued; the queue drains normally.
- `reset` asserted mid-operation: all state returns to reset values asynchronously; an outstanding memory response is ignored.

## Timing
- Cycle 0 = first rising edge with `reset`=1. `mem_rd`=1 and `mem_addr`=0 during cycle 0.
- Data for address 0 is present in cycle 1 and written at the end of cycle 1. `instr_valid`=1 with `instr_pc`=0 in cycle 2.
- Fetch-to-valid latency is 2 cycles. Throughput is 1 word/cycle with `instr_ready` held at 1.
- Redirect at cycle N: `mem_rd`=1 with `mem_addr`=`redirect_pc` in cycle N+1. The first redirected word is valid in cycle N+3.
- Stalled consumer (`instr_ready`=0): the queue fills to DEPTH, then `mem_rd` drops. At most DEPTH words are queued and none are lost.
- All outputs are registered or decoded from registered state. `mem_rd` additionally depends combinationally on `halt` and `redirect`.

## Structure
- Shared package `processor_8085_pkg`: default ADDR_W/DATA_W, and a fetch-entry struct {pc, word} used by this block and by decode.
- Sub-module `fetch_fifo`: synchronous FIFO of DEPTH entries of (ADDR_W+DATA_W) bits. It has push/pop/flush inputs, full/empty/count outputs and a registered head. The top level holds the issue logic, fetch_pc and the in-flight tracking.

## Test plan
- Reset release, memory words[0..7]=0x0003,0x0000,…, `instr_ready`=1 → `mem_rd` in cycle 0. `instr_valid` rises in cycle 2 with `instr`=0x0003 and `instr_pc`=0, then one word per cycle in address order.
- `instr_ready`=0 from reset → `q_count` reaches 4 and `mem_rd`=0 afterwards. Releasing ready yields addresses 0,1,2,3,4… with no gaps or duplicates.
- `redirect`=1 with `redirect_pc`=0x40 while 3 words are queued and 1 is in flight → the next cycle has `q_count`=0 and `mem_addr`=0x40. The first accepted word has `instr_pc`=0x40; the dropped addresses never appear.
- Start at `redirect_pc`=0xFE → `instr_pc` sequence 0xFE, 0xFF, 0x00, 0x01 (wrap).
- `halt`=1 one cycle after an issue → that word is still queued, no further `mem_rd`, and `fetch_pc` frozen. Deasserting resumes at the next address.
- `reset` pulled low for 3 ns mid-stream with a full queue → all outputs at reset values immediately. Restart fetches from address 0.

Source files
------------

// File: rtl/processor_8085_pkg.sv
// Shared 8085 front-end types: default bus widths and the fetch-queue entry.
package processor_8085_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  // One prefetched instruction word together with the address it came from.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush and a head decoded from registered state.
module fetch_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (push && !pop)      r_count <= r_count + CW'(1);
      else if (!push && pop) r_count <= r_count - CW'(1);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/fetch_unit_8085.sv
// Instruction prefetch: issues sequential reads, tracks the in-flight word, queues responses.
module fetch_unit_8085
  import processor_8085_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instr,
  output logic [ADDR_W-1:0]      instr_pc,
  input  logic                   instr_ready,
  output logic [ADDR_W-1:0]      fetch_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [ADDR_W-1:0] r_fetch_pc;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [EW-1:0]     w_head;
  logic [CW-1:0]     w_count;
  logic [OW-1:0]     w_occ;

  // Credit check counts the in-flight word; a same-cycle pop earns no credit.
  assign w_occ  = {1'b0, w_count} + OW'(r_inflight);
  assign mem_rd = reset && !halt && !redirect && (w_occ < OW'(DEPTH));

  // Redirect drops the arriving response and suppresses any pop.
  assign w_push = r_inflight && !redirect && !w_full;
  assign w_pop  = !w_empty && instr_ready && !redirect;

  // Fetch address and in-flight tracking; redirect overrides issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= mem_rd;
      if (mem_rd) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect),
    .din   ({r_inflight_pc, mem_rdata}),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign mem_addr    = r_fetch_pc;
  assign fetch_pc    = r_fetch_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_head[DATA_W-1:0];
  assign instr_pc    = w_head[EW-1:DATA_W];
  assign q_count     = w_count;

endmodule

// File: tb/tb_fetch_unit_8085.sv
// Bench for fetch_unit_8085: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit_8085;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;
  logic [7:0]  fetch_pc;
  logic [2:0]  q_count;

  logic [15:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of addresses held, in-flight word, next fetch and next expected accept.
  int  mq[$];
  bit  m_out;
  int  m_out_pc;
  int  m_fetch;
  int  m_accept;
  bit  model_en = 0;

  fetch_unit_8085 dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_pc    (fetch_pc),
    .q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out    = 0;
    m_out_pc = 0;
    m_fetch  = 0;
    m_accept = 0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model across the edge.
  task automatic model_cycle();
    bit exp_rd;
    exp_rd = !halt && !redirect && ((mq.size() + (m_out ? 1 : 0)) < 4);
    chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
    chk("mem_addr", 32'(mem_addr), 32'(m_fetch));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_fetch));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    chk("q_count", 32'(q_count), 32'(mq.size()));
    if (mq.size() > 0) begin
      chk("instr_pc", 32'(instr_pc), 32'(mq[0]));
      chk("instr", 32'(instr), 32'(mem[mq[0]]));
    end
    if (redirect) begin
      mq.delete();
      m_out    = 0;
      m_fetch  = int'(redirect_pc);
      m_accept = int'(redirect_pc);
    end else begin
      if (mq.size() > 0 && instr_ready) begin
        chk("accept_seq", 32'(instr_pc), 32'(m_accept));
        m_accept = (m_accept + 1) % 256;
        void'(mq.pop_front());
      end
      if (m_out) mq.push_back(m_out_pc);
      m_out    = exp_rd;
      m_out_pc = m_fetch;
      if (exp_rd) m_fetch = (m_fetch + 1) % 256;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_en) model_cycle();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse mid-cycle; the next rising edge is cycle 0.
  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'(0));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_fetch_pc"}, 32'(fetch_pc), 32'(0));
    chk({tag, "_valid"}, 32'(instr_valid), 32'(0));
    chk({tag, "_instr"}, 32'(instr), 32'(0));
    chk({tag, "_instr_pc"}, 32'(instr_pc), 32'(0));
    chk({tag, "_q_count"}, 32'(q_count), 32'(0));
  endtask

  initial begin
    int f0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0003;
    mem[1] = 16'h0000;
    reset       = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b1;
    mem_rdata   = 16'h0000;

    // Reset state and first-fetch latency
    @(posedge clk);
    #2;
    chk_reset_vals("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    model_en = 1;
    #1;
    chk("c0_mem_rd", 32'(mem_rd), 32'(1));
    chk("c0_mem_addr", 32'(mem_addr), 32'(0));
    tick();
    chk("c1_valid", 32'(instr_valid), 32'(0));
    tick();
    chk("c2_valid", 32'(instr_valid), 32'(1));
    chk("c2_instr", 32'(instr), 32'(16'h0003));
    chk("c2_pc", 32'(instr_pc), 32'(0));
    tick();
    chk("c3_pc", 32'(instr_pc), 32'(1));
    chk("c3_instr", 32'(instr), 32'(16'h0000));
    repeat (6) tick();

    // Redirect with three words queued and one in flight
    instr_ready = 1'b0;
    pulse_reset();
    repeat (4) tick();
    chk("rd_pre_q_count", 32'(q_count), 32'(3));
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    #1;
    chk("rd_q_count", 32'(q_count), 32'(0));
    chk("rd_mem_addr", 32'(mem_addr), 32'(8'h40));
    chk("rd_mem_rd", 32'(mem_rd), 32'(1));
    instr_ready = 1'b1;
    repeat (2) tick();
    chk("rd_first_valid", 32'(instr_valid), 32'(1));
    chk("rd_first_pc", 32'(instr_pc), 32'(8'h40));
    repeat (4) tick();

    // Stalled consumer fills the queue, then drains in order
    instr_ready = 1'b0;
    pulse_reset();
    repeat (8) tick();
    chk("stall_q_count", 32'(q_count), 32'(4));
    chk("stall_mem_rd", 32'(mem_rd), 32'(0));
    chk("stall_fetch_pc", 32'(fetch_pc), 32'(4));
    instr_ready = 1'b1;
    repeat (10) tick();

    // Fetch address wrap
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    chk("wrap0", 32'(instr_pc), 32'(8'hFE));
    tick();
    chk("wrap1", 32'(instr_pc), 32'(8'hFF));
    tick();
    chk("wrap2", 32'(instr_pc), 32'(8'h00));
    tick();
    chk("wrap3", 32'(instr_pc), 32'(8'h01));

    // Halt right after an issue: in-flight word still lands, fetch_pc frozen
    halt = 1'b1;
    #1;
    chk("halt_mem_rd", 32'(mem_rd), 32'(0));
    f0 = m_fetch;
    repeat (3) tick();
    chk("halt_fetch_pc", 32'(fetch_pc), 32'(f0));
    chk("halt_mem_rd2", 32'(mem_rd), 32'(0));
    halt = 1'b0;
    #1;
    chk("resume_mem_rd", 32'(mem_rd), 32'(1));
    chk("resume_addr", 32'(mem_addr), 32'(f0));
    repeat (6) tick();

    // Asynchronous reset mid-stream with a full queue
    instr_ready = 1'b0;
    repeat (6) tick();
    chk("full_q_count", 32'(q_count), 32'(4));
    reset = 1'b0;
    #1;
    chk_reset_vals("async");
    #2;
    reset = 1'b1;
    model_reset();
    instr_ready = 1'b1;
    repeat (2) tick();
    chk("restart_valid", 32'(instr_valid), 32'(1));
    chk("restart_pc", 32'(instr_pc), 32'(0));
    chk("restart_instr", 32'(instr), 32'(16'h0003));

    // Random traffic checked cycle by cycle against the model
    for (int n = 0; n < 1500; n++) begin
      instr_ready = ($urandom_range(9) < 7);
      halt        = ($urandom_range(9) == 0);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = 8'($urandom);
      tick();
    end
    halt     = 1'b0;
    redirect = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
